cam_entry_manager: RTL
======================

Name: cam_entry_manager

Overview:
Write-side companion placed directly upstream of the CAM search array. It accepts insert and delete requests on a valid/ready interface and keeps a mirror of the stored keys plus a per-entry valid bitmap. It detects duplicate keys and allocates the lowest free slot. It drives a single-cycle write port into the CAM storage and returns a status/index response per request.

Parameters:
DATA_WIDTH, 8, key width in bits
DEPTH, 8, number of CAM entries (power of two, >=2)
IDX_W, $clog2(DEPTH), localparam, index width
CNT_W, $clog2(DEPTH+1), localparam, occupancy width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset: synchronous, active-high; only clk edges act on it
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid&&req_ready
req_op  input  1  0=INSERT, 1=DELETE
req_key  input  DATA_WIDTH  key to insert/delete
resp_valid  output  1  one-cycle response pulse, no backpressure
resp_status  output  2  00 OK, 01 DUPLICATE, 10 FULL, 11 NOT_FOUND
resp_index  output  IDX_W  entry index affected or hit
wr_en  output  1  one-cycle write strobe to CAM storage
wr_index  output  IDX_W  entry written
wr_key  output  DATA_WIDTH  key written (0 on delete)
wr_valid  output  1  new valid bit for wr_index
entry_valid  output  DEPTH  valid bitmap, bit i = entry i occupied
occupancy  output  CNT_W  popcount of entry_valid

Behaviour:
- Reset (synchronous): state=IDLE, mirror keys=0, entry_valid=0, occupancy=0, resp_valid=0, resp_status=0, resp_index=0, wr_en=0, wr_index=0, wr_key=0, wr_valid=0. req_ready=(state==IDLE)&&!rst, so it is 0 while rst is high.
- FSM: IDLE -> LOOKUP -> COMMIT -> RESP -> IDLE. Handshake in IDLE only. Request fields latched at acceptance.
- LOOKUP (cycle 1): compare the latched key against mirror entries whose valid bit is set; invalid entries never hit. Compute hit, hit_idx (lowest matching), free (any zero in entry_valid) and free_idx (lowest zero).
- COMMIT (cycle 2):
  - INSERT, no hit, free: wr_en=1, wr_index=free_idx, wr_key=key, wr_valid=1. Mirror and valid bit updated on the same edge; status OK, index=free_idx.
  - INSERT with hit: no write, status DUPLICATE, index=hit_idx. The duplicate check takes priority over FULL.
  - INSERT, no hit, full: no write, status FULL, index=0.
  - DELETE with hit: wr_en=1, wr_index=hit_idx, wr_key=0, wr_valid=0. Mirror entry is cleared and its valid bit dropped; status OK, index=hit_idx.
  - DELETE, no hit: no write, status NOT_FOUND, index=0.
- RESP (cycle 3): resp_valid=1 for exactly one cycle. resp_status and resp_index hold until the next response.
- Latency: accept edge 0, wr_en asserted during cycle 2, resp_valid during cycle 3, req_ready high again in cycle 4. Peak throughput is 1 request per 4 cycles.
- wr_en is a single-cycle pulse and is 0 in every other state. occupancy updates on the same edge as entry_valid.
- Reset mid-operation: the request is abandoned with no wr_en and no resp_valid. All state returns to reset values.

Optional Feature:
CAM_MGR_FLUSH_EN
- Defined: adds input flush (1 bit).
  - When flush=1 in IDLE, flush takes priority over req_valid and the FSM enters FLUSH with req_ready=0.
  - FLUSH emits DEPTH consecutive wr_en pulses for indices 0..DEPTH-1, each with wr_key=0 and wr_valid=0.
  - entry_valid and mirror are cleared progressively. The FSM then returns to IDLE.
  - No resp_valid is produced for a flush.
  - flush in any state other than IDLE is ignored.
- Undefined: the port and FLUSH state are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package cam_pkg: op encoding (OP_INSERT/OP_DELETE), status codes (ST_OK, ST_DUP, ST_FULL, ST_NOTFOUND), FSM state enum.
- One sub-module, cam_prio_enc: parameterized lowest-set-bit priority encoder (any, idx).
  - Instantiated twice: on the hit vector, and on ~entry_valid for free-slot selection.

Test Plan:
- Reset, then INSERT 0x3C -> cycle 2 wr_en=1, wr_index=0, wr_key=0x3C, wr_valid=1; cycle 3 resp OK, index 0; occupancy=1.
- INSERT 0x3C again -> no wr_en; resp DUPLICATE, index 0; occupancy stays 1.
- Insert 8 distinct keys (0x10..0x17), then INSERT 0x99 -> resp FULL, index 0; no wr_en; entry_valid=0xFF.
- DELETE 0x13 (index 3) -> wr_en, wr_index=3, wr_valid=0, resp OK, index 3. Then INSERT 0x77 -> written at index 3; occupancy returns to 8.
- DELETE 0x55 (absent) -> resp NOT_FOUND, index 0; no wr_en. INSERT while req_valid held continuously -> req_ready pulses every 4th cycle.
- Assert rst during LOOKUP for 1 cycle -> no wr_en, no resp_valid, entry_valid=0, occupancy=0; req_ready=1 on the first cycle after rst falls.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared encodings for the CAM entry manager
// S_FLUSH exists only when CAM_MGR_FLUSH_EN is defined.
package cam_pkg;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_DUP      = 2'b01;
  localparam logic [1:0] ST_FULL     = 2'b10;
  localparam logic [1:0] ST_NOTFOUND = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMMIT,
    S_RESP
`ifdef CAM_MGR_FLUSH_EN
    ,
    S_FLUSH
`endif
  } state_t;

endpackage

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - lowest-set-bit priority encoder
module cam_prio_enc #(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    any = |vec;
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cam_entry_manager.sv
// rtl/cam_entry_manager.sv - insert/delete manager and write port for a CAM array
// Optional bulk clear via the flush input when CAM_MGR_FLUSH_EN is defined.
module cam_entry_manager
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CAM_MGR_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  resp_valid,
  output logic [1:0]            resp_status,
  output logic [IDX_W-1:0]      resp_index,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      wr_index,
  output logic [DATA_WIDTH-1:0] wr_key,
  output logic                  wr_valid,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [CNT_W-1:0]      occupancy
);

  state_t                state;
  logic                  op_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [DATA_WIDTH-1:0] mirror [DEPTH];
  logic [1:0]            st_q;
  logic [IDX_W-1:0]      ridx_q;

  logic [DEPTH-1:0]      hit_vec;
  logic                  hit, free;
  logic [IDX_W-1:0]      hit_idx, free_idx;

  logic                  do_wr, c_valid;
  logic [IDX_W-1:0]      c_idx, c_ridx;
  logic [DATA_WIDTH-1:0] c_key;
  logic [1:0]            c_status;
  logic [DEPTH-1:0]      next_valid;
  logic [CNT_W-1:0]      next_cnt;

  assign req_ready = (state == S_IDLE) && !rst;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = entry_valid[i] && (mirror[i] == key_q);
    end
  end

  cam_prio_enc #(.N(DEPTH)) u_hit_enc (.vec(hit_vec), .any(hit), .idx(hit_idx));
  cam_prio_enc #(.N(DEPTH)) u_free_enc (.vec(~entry_valid), .any(free), .idx(free_idx));

  // Duplicate detection outranks FULL for inserts.
  always_comb begin
    do_wr    = 1'b0;
    c_idx    = '0;
    c_key    = '0;
    c_valid  = 1'b0;
    c_status = ST_OK;
    c_ridx   = '0;
    if (op_q == OP_INSERT) begin
      if (hit) begin
        c_status = ST_DUP;
        c_ridx   = hit_idx;
      end else if (free) begin
        do_wr   = 1'b1;
        c_idx   = free_idx;
        c_key   = key_q;
        c_valid = 1'b1;
        c_ridx  = free_idx;
      end else begin
        c_status = ST_FULL;
      end
    end else begin
      if (hit) begin
        do_wr  = 1'b1;
        c_idx  = hit_idx;
        c_ridx = hit_idx;
      end else begin
        c_status = ST_NOTFOUND;
      end
    end
  end

  always_comb begin
    next_valid = entry_valid;
    if (state == S_LOOKUP && do_wr) next_valid[c_idx] = c_valid;
`ifdef CAM_MGR_FLUSH_EN
    if (state == S_IDLE && flush) next_valid[0] = 1'b0;
    if (state == S_FLUSH && wr_index != IDX_W'(DEPTH - 1)) next_valid[wr_index + 1'b1] = 1'b0;
`endif
    next_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      next_cnt = next_cnt + CNT_W'(next_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= 1'b0;
      key_q       <= '0;
      st_q        <= ST_OK;
      ridx_q      <= '0;
      entry_valid <= '0;
      occupancy   <= '0;
      resp_valid  <= 1'b0;
      resp_status <= ST_OK;
      resp_index  <= '0;
      wr_en       <= 1'b0;
      wr_index    <= '0;
      wr_key      <= '0;
      wr_valid    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mirror[i] <= '0;
    end else begin
      wr_en       <= 1'b0;
      resp_valid  <= 1'b0;
      entry_valid <= next_valid;
      occupancy   <= next_cnt;
      case (state)
        S_IDLE: begin
`ifdef CAM_MGR_FLUSH_EN
          if (flush) begin
            state     <= S_FLUSH;
            wr_en     <= 1'b1;
            wr_index  <= '0;
            wr_key    <= '0;
            wr_valid  <= 1'b0;
            mirror[0] <= '0;
          end else
`endif
          if (req_valid) begin
            op_q  <= req_op;
            key_q <= req_key;
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          state  <= S_COMMIT;
          st_q   <= c_status;
          ridx_q <= c_ridx;
          if (do_wr) begin
            wr_en         <= 1'b1;
            wr_index      <= c_idx;
            wr_key        <= c_key;
            wr_valid      <= c_valid;
            mirror[c_idx] <= c_key;
          end
        end
        S_COMMIT: begin
          state       <= S_RESP;
          resp_valid  <= 1'b1;
          resp_status <= st_q;
          resp_index  <= ridx_q;
        end
        S_RESP: state <= S_IDLE;
`ifdef CAM_MGR_FLUSH_EN
        S_FLUSH: begin
          if (wr_index == IDX_W'(DEPTH - 1)) begin
            state <= S_IDLE;
          end else begin
            wr_en                     <= 1'b1;
            wr_index                  <= wr_index + 1'b1;
            mirror[wr_index + 1'b1]   <= '0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
